// File: rtl/program_loader.sv
// program_loader: streams a length-prefixed program into the computer's ROM through
// its programming port, then pulses the CPU reset so execution restarts at unit 0.
module program_loader #(
  parameter int SEND_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       rstROM,
  output logic       edit,
  output logic [7:0] unit,
  output logic [7:0] code,
  output logic       send,
  output logic       cpu_rst,
  output logic       busy,
  output logic       done,
  output logic [7:0] count
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    GETLEN,
    GETBYTE,
    SEND,
    GAP,
    RELEASE
  } state_t;

  state_t     state;
  state_t     nstate;
  logic [7:0] remaining;
  logic [7:0] nremaining;
  logic [7:0] nunit;
  logic [7:0] ncode;
  logic [7:0] ncount;
  logic [3:0] sendcnt;
  logic [3:0] nsendcnt;
  logic       xfer;

  assign xfer = in_valid && in_ready;

  // Next-state and datapath updates; unit/count are cleared on the way into CLEAR
  // so they already read 0 while the ROM is being erased.
  always_comb begin
    nstate     = state;
    nremaining = remaining;
    nunit      = unit;
    ncode      = code;
    ncount     = count;
    nsendcnt   = sendcnt;
    case (state)
      IDLE: begin
        if (start) begin
          nstate = CLEAR;
          nunit  = 8'd0;
          ncount = 8'd0;
        end
      end
      CLEAR: nstate = GETLEN;
      GETLEN: begin
        if (xfer) begin
          nremaining = in_data;
          nstate     = (in_data == 8'd0) ? RELEASE : GETBYTE;
        end
      end
      GETBYTE: begin
        if (xfer) begin
          ncode    = in_data;
          nsendcnt = 4'd0;
          nstate   = SEND;
        end
      end
      SEND: begin
        if (sendcnt == 4'(SEND_CYCLES - 1)) nstate = GAP;
        else nsendcnt = sendcnt + 4'd1;
      end
      GAP: begin
        nunit      = unit + 8'd1;
        ncount     = count + 8'd1;
        nremaining = remaining - 8'd1;
        nstate     = (remaining == 8'd1) ? RELEASE : GETBYTE;
      end
      RELEASE: nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Port strobes are decoded from the next state and registered, so each one
  // lines up exactly with the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= 8'd0;
      sendcnt   <= 4'd0;
      unit      <= 8'd0;
      code      <= 8'd0;
      count     <= 8'd0;
      in_ready  <= 1'b0;
      rstROM    <= 1'b0;
      edit      <= 1'b0;
      send      <= 1'b0;
      cpu_rst   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= nstate;
      remaining <= nremaining;
      sendcnt   <= nsendcnt;
      unit      <= nunit;
      code      <= ncode;
      count     <= ncount;
      in_ready  <= (nstate == GETLEN) || (nstate == GETBYTE);
      rstROM    <= (nstate == CLEAR);
      edit      <= (nstate == CLEAR) || (nstate == GETLEN) || (nstate == GETBYTE) ||
                   (nstate == SEND) || (nstate == GAP);
      send      <= (nstate == SEND);
      cpu_rst   <= (nstate == RELEASE);
      busy      <= (nstate != IDLE);
      done      <= (nstate == RELEASE);
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed checks of the ROM download sequence, backpressure,
// mid-download reset and the full 255-byte program.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       rstROM;
  logic       edit;
  logic [7:0] unit;
  logic [7:0] code;
  logic       send;
  logic       cpu_rst;
  logic       busy;
  logic       done;
  logic [7:0] count;

  int errors = 0;
  int checks = 0;

  logic [7:0] strm [0:299];
  int         slen = 0;
  int         sidx;
  logic       srcrst;
  logic       validen;

  program_loader #(.SEND_CYCLES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .rstROM   (rstROM),
    .edit     (edit),
    .unit     (unit),
    .code     (code),
    .send     (send),
    .cpu_rst  (cpu_rst),
    .busy     (busy),
    .done     (done),
    .count    (count)
  );

  always #5 clk = ~clk;

  // Byte source: presents the next stream byte and advances on each transfer.
  assign in_data  = (sidx < 300) ? strm[sidx] : 8'h00;
  assign in_valid = validen && (sidx < slen);

  always @(posedge clk) begin
    if (srcrst) sidx <= 0;
    else if (in_valid && in_ready) sidx <= sidx + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] len, input logic [7:0] first, input logic [7:0] step);
    strm[0] = len;
    for (int i = 1; i <= 256; i++) strm[i] = 8'(first + 8'(step * (i - 1)));
    slen    = int'(len) + 1;
    validen = 1'b1;
    srcrst  = 1'b1;
    tick();
    srcrst  = 1'b0;
  endtask

  // Stream 03,AA,BB,CC with in_valid held high; start driven in cycle 0.
  task automatic runScenario1(input logic extraStart);
    logic expSend;
    int   k;
    applyStimulus(8'h03, 8'hAA, 8'h11);
    start = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      start = (extraStart && c == 6) ? 1'b1 : 1'b0;
      expSend = (c == 4 || c == 5 || c == 8 || c == 9 || c == 12 || c == 13);
      checkOutput($sformatf("s1_send_c%0d", c), 32'(send), 32'(expSend));
      checkOutput($sformatf("s1_edit_c%0d", c), 32'(edit), 32'(c >= 1 && c <= 14));
      checkOutput($sformatf("s1_rstROM_c%0d", c), 32'(rstROM), 32'(c == 1));
      checkOutput($sformatf("s1_done_c%0d", c), 32'(done), 32'(c == 15));
      checkOutput($sformatf("s1_cpurst_c%0d", c), 32'(cpu_rst), 32'(c == 15));
      checkOutput($sformatf("s1_busy_c%0d", c), 32'(busy), 32'(c <= 15));
      checkOutput($sformatf("s1_inready_c%0d", c), 32'(in_ready),
                  32'(c == 2 || c == 3 || c == 7 || c == 11));
      if (expSend) begin
        k = (c - 4) / 4;
        checkOutput($sformatf("s1_unit_c%0d", c), 32'(unit), 32'(k));
        checkOutput($sformatf("s1_code_c%0d", c), 32'(code), 32'(8'hAA + 8'h11 * k));
      end
      if (c == 15) checkOutput("s1_count_done", 32'(count), 32'h3);
    end
  endtask

  initial begin
    logic [7:0] lastUnit;
    logic [7:0] lastCode;
    logic       found;
    int         doneCycle;
    $display("[TB] program_loader directed test");
    rst     = 1'b1;
    start   = 1'b0;
    validen = 1'b0;
    srcrst  = 1'b1;
    tick();
    tick();
    rst    = 1'b0;
    srcrst = 1'b0;
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_outs", {24'(0), in_ready, rstROM, edit, send, cpu_rst, done},
                32'h0);
    checkOutput("reset_unit_code_count", {8'h0, unit, code, count}, 32'h0);

    runScenario1(1'b0);

    // Reset in cycle 5 aborts cleanly, then a fresh start repeats scenario 1.
    applyStimulus(8'h03, 8'hAA, 8'h11);
    start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      start = 1'b0;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rstmid_flags", {24'(0), busy, in_ready, rstROM, edit, send, cpu_rst, done},
                32'h0);
    checkOutput("rstmid_data", {8'h0, unit, code, count}, 32'h0);
    for (int c = 7; c <= 12; c++) begin
      tick();
      checkOutput($sformatf("rstmid_nodone_c%0d", c), {30'(0), done, busy}, 32'h0);
    end
    runScenario1(1'b0);

    // Start pulsed while busy must not disturb the waveform.
    runScenario1(1'b1);

    // Start and reset together leave the loader idle.
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    checkOutput("start_rst_busy", 32'(busy), 32'h0);
    tick();
    checkOutput("start_rst_idle", {29'(0), busy, edit, rstROM}, 32'h0);

    // Zero-length stream.
    applyStimulus(8'h00, 8'h00, 8'h00);
    start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      start = 1'b0;
      checkOutput($sformatf("z_send_c%0d", c), 32'(send), 32'h0);
      checkOutput($sformatf("z_rstROM_c%0d", c), 32'(rstROM), 32'(c == 1));
      checkOutput($sformatf("z_inready_c%0d", c), 32'(in_ready), 32'(c == 2));
      checkOutput($sformatf("z_done_c%0d", c), {30'(0), done, cpu_rst},
                  (c == 3) ? 32'h3 : 32'h0);
      if (c == 3) checkOutput("z_count", 32'(count), 32'h0);
    end

    // Backpressure: 02,11,22 with in_valid low for cycles 7..11.
    applyStimulus(8'h02, 8'h11, 8'h11);
    start = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      tick();
      start = 1'b0;
      if (c == 7) validen = 1'b0;
      if (c == 12) validen = 1'b1;
      if (c >= 7 && c <= 12)
        checkOutput($sformatf("bp_wait_c%0d", c), {28'(0), in_ready, send, edit, busy},
                    32'hB);
      if (c == 4) checkOutput("bp_first", {15'(0), send, unit, code}, {15'(0), 1'b1, 8'h00, 8'h11});
      if (c == 13 || c == 14)
        checkOutput($sformatf("bp_second_c%0d", c), {15'(0), send, unit, code},
                    {15'(0), 1'b1, 8'h01, 8'h22});
      if (c == 15) checkOutput("bp_gap", 32'(send), 32'h0);
      if (c == 16) checkOutput("bp_done", {22'(0), done, cpu_rst, count}, {22'(0), 2'b11, 8'h02});
    end

    // Full 255-byte program with bytes 00..FE.
    applyStimulus(8'hFF, 8'h00, 8'h01);
    start     = 1'b1;
    found     = 1'b0;
    doneCycle = 0;
    lastUnit  = 8'h00;
    lastCode  = 8'h00;
    for (int c = 1; c <= 2000 && !found; c++) begin
      tick();
      start = 1'b0;
      if (send) begin
        lastUnit = unit;
        lastCode = code;
      end
      if (done) begin
        found     = 1'b1;
        doneCycle = c;
        checkOutput("ff_count", 32'(count), 32'hFF);
      end
    end
    checkOutput("ff_done_seen", 32'(found), 32'h1);
    checkOutput("ff_latency", 32'(doneCycle), 32'd1023);
    checkOutput("ff_last_unit", 32'(lastUnit), 32'hFE);
    checkOutput("ff_last_code", 32'(lastCode), 32'hFE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
